// File: rtl/cymometer_mc.sv
`timescale 1ns/1ps
// cymometer_mc -- multi-channel equal-precision frequency meter.
//
// Channels are measured one after another. For each channel the gate opens
// on a rising edge of the measured signal and closes on the gate_time-th
// following rising edge. Counting reference cycles between those two edges
// gives an exact edge count, so the only error is the reference-cycle
// quantisation. The result is fx = fx_cnt * CLK_FS / fs_cnt, computed with
// one registered multiply and a restoring divider (one quotient bit/cycle).
//
// Ports
//   clk_fs      reference clock (rising edge), the only clock
//   rst_n       asynchronous active-low reset
//   sig_in      CH_NUM asynchronous measured signals
//   gate_time   gate length in measured-signal rising edges (0 acts as 1)
//   start       one-cycle pulse, starts a sweep at channel 0 (IDLE only)
//   cont        1: restart the sweep at channel 0 after the last channel
//   busy        high while a sweep is in progress
//   data_valid  one-cycle result strobe
//   data_ch     channel of the current result
//   data_fx     measured frequency in Hz (saturates at all ones)
//   timeout     qualifies data_valid: channel saw no edges, data_fx = 0
module cymometer_mc #(
    parameter int unsigned CLK_FS  = 32'd50_000_000,
    parameter int          CH_NUM  = 4,
    parameter int          GATE_W  = 16,
    parameter int          OUT_W   = 32,
    parameter int unsigned TIMEOUT = 32'd25_000_000,
    localparam int         CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk_fs,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] sig_in,
    input  logic [GATE_W-1:0] gate_time,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic              data_valid,
    output logic [CH_W-1:0]   data_ch,
    output logic [OUT_W-1:0]  data_fx,
    output logic              timeout
);

    localparam int DIV_W = GATE_W + 32;
    localparam int CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CH_NUM-1:0] sync1, sync2, sync3, rise;
    logic [CH_W-1:0]   ch;
    logic [GATE_W-1:0] gate_lat, fx_cnt;
    logic [31:0]       fs_cnt, idle_cnt;
    logic [DIV_W-1:0]  quo, quo_nxt;
    logic [31:0]       rem, rem_nxt;
    logic [32:0]       rem_sh;
    logic [CNT_W-1:0]  div_cnt;
    logic              rise_ch, gate_end, to_hit, div_last, ch_last, rem_ge, q_sat;
    logic [OUT_W-1:0]  fx_res;

    // Per-channel 2-FF synchroniser followed by a registered rising-edge detect.
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            rise  <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

    assign rise_ch  = rise[ch];
    assign gate_end = rise_ch && ((fx_cnt + GATE_W'(1)) == gate_lat);
    // No edge for TIMEOUT cycles, or the reference counter about to wrap.
    assign to_hit   = (!rise_ch && (idle_cnt >= (TIMEOUT - 32'd1))) ||
                      ((state == S_GATE) && (fs_cnt == '1));
    assign div_last = (div_cnt == CNT_W'(DIV_W - 1));
    assign ch_last  = (ch == CH_W'(CH_NUM - 1));

    // Restoring divider step. rem < fs_cnt always holds, so rem fits 32 bits.
    assign rem_sh  = {rem, quo[DIV_W-1]};
    assign rem_ge  = (rem_sh >= {1'b0, fs_cnt});
    assign rem_nxt = rem_ge ? 32'(rem_sh - {1'b0, fs_cnt}) : rem_sh[31:0];
    assign quo_nxt = {quo[DIV_W-2:0], rem_ge};
    assign q_sat   = (quo_nxt > DIV_W'({OUT_W{1'b1}}));
    assign fx_res  = q_sat ? '1 : quo_nxt[OUT_W-1:0];

    // FSM: state register
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_ARM;
            S_ARM: begin
                if (rise_ch)     state_nxt = S_GATE;
                else if (to_hit) state_nxt = S_DONE;
            end
            S_GATE: begin
                if (gate_end)    state_nxt = S_MUL;
                else if (to_hit) state_nxt = S_DONE;
            end
            S_MUL:  state_nxt = S_DIV;
            S_DIV:  if (div_last) state_nxt = S_DONE;
            S_DONE: state_nxt = (!ch_last || cont) ? S_ARM : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state != S_IDLE);
        data_valid = (state == S_DONE);
    end

    // Datapath: counters, divider and result registers.
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            ch       <= '0;
            gate_lat <= '0;
            fx_cnt   <= '0;
            fs_cnt   <= '0;
            idle_cnt <= '0;
            quo      <= '0;
            rem      <= '0;
            div_cnt  <= '0;
            data_ch  <= '0;
            data_fx  <= '0;
            timeout  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ch       <= '0;
                    idle_cnt <= '0;
                end
                S_ARM: begin
                    gate_lat <= (gate_time == '0) ? GATE_W'(1) : gate_time;
                    fx_cnt   <= '0;
                    fs_cnt   <= 32'd1;
                    idle_cnt <= rise_ch ? '0 : idle_cnt + 32'd1;
                    if (!rise_ch && to_hit) begin
                        data_ch <= ch;
                        data_fx <= '0;
                        timeout <= 1'b1;
                    end
                end
                S_GATE: begin
                    idle_cnt <= rise_ch ? '0 : idle_cnt + 32'd1;
                    if (rise_ch) fx_cnt <= fx_cnt + GATE_W'(1);
                    // fs_cnt holds on the closing edge: it counts the cycles
                    // between opening and closing edges, i.e. whole periods.
                    if (!gate_end) fs_cnt <= fs_cnt + 32'd1;
                    if (!gate_end && to_hit) begin
                        data_ch <= ch;
                        data_fx <= '0;
                        timeout <= 1'b1;
                    end
                end
                S_MUL: begin
                    quo     <= DIV_W'(fx_cnt) * DIV_W'(CLK_FS);
                    rem     <= '0;
                    div_cnt <= '0;
                end
                S_DIV: begin
                    quo     <= quo_nxt;
                    rem     <= rem_nxt;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_last) begin
                        data_ch <= ch;
                        data_fx <= fx_res;
                        timeout <= 1'b0;
                    end
                end
                S_DONE: begin
                    ch       <= ch_last ? '0 : ch + CH_W'(1);
                    idle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
